// File: rtl/mem_req_queue.sv
// Per-bank request FIFO in front of the bank controller. The head entry drives
// the bank enable/address lanes until the bank acks; a read completion produces
// a one-cycle response pulse.
module mem_req_queue #(
  parameter int DEPTH           = 4,
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int COL_ADDR_WIDTH  = 4,
  parameter int TX_DATA_WIDTH   = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [BANK_ADDR_WIDTH-1:0]     req_row,
  input  logic [COL_ADDR_WIDTH-1:0]      req_col,
  input  logic [TX_DATA_WIDTH-1:0]       req_data,
  output logic                           mem_write_en,
  output logic                           mem_read_en,
  output logic [BANK_ADDR_WIDTH-1:0]     mem_row,
  output logic [COL_ADDR_WIDTH-1:0]      mem_col,
  output logic [TX_DATA_WIDTH-1:0]       mem_wdata,
  input  logic                           mem_ack,
  input  logic [TX_DATA_WIDTH-1:0]       mem_rdata,
  output logic                           rsp_valid,
  output logic [TX_DATA_WIDTH-1:0]       rsp_data,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                       q_write [DEPTH];
  logic [BANK_ADDR_WIDTH-1:0] q_row   [DEPTH];
  logic [COL_ADDR_WIDTH-1:0]  q_col   [DEPTH];
  logic [TX_DATA_WIDTH-1:0]   q_data  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          nonempty;
  logic          push;
  logic          pop;
  logic          head_write;

  assign nonempty   = (count != '0);
  // Ready depends on count only: a pop while full does not open a slot this cycle.
  assign req_ready  = (count < CW'(DEPTH));
  assign push       = req_valid && req_ready;
  assign pop        = nonempty && mem_ack;
  assign head_write = q_write[rd_ptr];
  assign idle       = !nonempty && !rsp_valid;

  always_comb begin
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    mem_row      = '0;
    mem_col      = '0;
    mem_wdata    = '0;
    if (nonempty) begin
      mem_write_en = head_write;
      mem_read_en  = !head_write;
      mem_row      = q_row[rd_ptr];
      mem_col      = q_col[rd_ptr];
      mem_wdata    = q_data[rd_ptr];
    end
  end

  // Entry storage needs no reset; it is only observed while count covers it.
  always_ff @(posedge clock) begin
    if (push) begin
      q_write[wr_ptr] <= req_write;
      q_row[wr_ptr]   <= req_row;
      q_col[wr_ptr]   <= req_col;
      q_data[wr_ptr]  <= req_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      rsp_valid <= pop && !head_write;
      if (pop && !head_write) rsp_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_req_queue.sv
// Randomised and directed bench for mem_req_queue: a queue-based reference
// model and a simple bank responder, compared against the DUT every cycle.
module tb_mem_req_queue;

  localparam int DEPTH = 4;
  localparam int RW    = 8;
  localparam int CLW   = 4;
  localparam int DW    = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_write = 1'b0;
  logic [RW-1:0]  req_row = '0;
  logic [CLW-1:0] req_col = '0;
  logic [DW-1:0]  req_data = '0;
  logic           mem_write_en, mem_read_en;
  logic [RW-1:0]  mem_row;
  logic [CLW-1:0] mem_col;
  logic [DW-1:0]  mem_wdata;
  logic           mem_ack = 1'b0;
  logic [DW-1:0]  mem_rdata = '0;
  logic           rsp_valid;
  logic [DW-1:0]  rsp_data;
  logic [2:0]     count;
  logic           idle;

  mem_req_queue #(.DEPTH(DEPTH), .BANK_ADDR_WIDTH(RW), .COL_ADDR_WIDTH(CLW),
                  .TX_DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_row(req_row), .req_col(req_col), .req_data(req_data),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_row(mem_row),
    .mem_col(mem_col), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .count(count), .idle(idle));

  always #5 clock = ~clock;

  typedef struct {
    logic           w;
    logic [RW-1:0]  row;
    logic [CLW-1:0] col;
    logic [DW-1:0]  data;
  } req_t;

  // reference state
  req_t          q[$];
  logic          m_rsp_v = 1'b0;
  logic [DW-1:0] m_rsp_d = '0;
  logic [DW-1:0] bmem [int];
  int            issued[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int dut_rsp_n = 0;

  // bank responder controls
  bit ack_mode = 0;
  bit ack_once = 0;
  int dmin = 0, dmax = 0;
  int cur_wait = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] bank_rd(input logic [RW-1:0] r, input logic [CLW-1:0] c);
    int k;
    k = {r, c};
    if (bmem.exists(k)) return bmem[k];
    return DW'(k * 37 + 5);
  endfunction

  // reference model: FIFO of requests, updated at each rising edge
  always @(posedge clock) begin
    bit   do_pop, do_push;
    req_t h, n;
    if (reset) begin
      q.delete();
      m_rsp_v = 1'b0;
      m_rsp_d = '0;
    end else begin
      do_pop  = (q.size() > 0) && mem_ack;
      do_push = req_valid && (q.size() < DEPTH);
      m_rsp_v = 1'b0;
      if (do_pop) begin
        h = q.pop_front();
        issued.push_back(int'(h.row));
        if (h.w) bmem[{h.row, h.col}] = h.data;
        else begin
          m_rsp_v = 1'b1;
          m_rsp_d = bank_rd(h.row, h.col);
        end
      end
      if (do_push) begin
        n.w = req_write; n.row = req_row; n.col = req_col; n.data = req_data;
        q.push_back(n);
      end
    end
  end

  // bank responder: acks the model's head after a chosen delay
  always @(negedge clock) begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if (reset) cur_wait = -1;
    else if (ack_once) begin
      mem_ack  = 1'b1;
      ack_once = 0;
      cur_wait = -1;
    end else if (ack_mode && q.size() > 0) begin
      if (cur_wait < 0) cur_wait = $urandom_range(dmax, dmin);
      if (cur_wait == 0) begin
        mem_ack  = 1'b1;
        cur_wait = -1;
      end else cur_wait--;
    end
    if (mem_ack && q.size() > 0 && !q[0].w) mem_rdata = bank_rd(q[0].row, q[0].col);
  end

  // per-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
      chk("write_en", 32'(mem_write_en), q.size() > 0 ? 32'(q[0].w) : 0);
      chk("read_en", 32'(mem_read_en), q.size() > 0 ? 32'(!q[0].w) : 0);
      chk("mem_row", 32'(mem_row), q.size() > 0 ? 32'(q[0].row) : 0);
      chk("mem_col", 32'(mem_col), q.size() > 0 ? 32'(q[0].col) : 0);
      chk("mem_wdata", 32'(mem_wdata), q.size() > 0 ? 32'(q[0].data) : 0);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
      chk("rsp_data", 32'(rsp_data), 32'(m_rsp_d));
      chk("idle", 32'(idle), 32'(q.size() == 0 && !m_rsp_v));
      if (rsp_valid === 1'b1) dut_rsp_n++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input bit v, input bit w, input int r, input int c, input int d);
    req_valid = v;
    req_write = w;
    req_row   = RW'(r);
    req_col   = CLW'(c);
    req_data  = DW'(d);
  endtask

  task automatic drain();
    ack_mode = 1;
    for (int i = 0; i < 100 && q.size() > 0; i++) tick();
    chk("drain_bound", 32'(q.size()), 0);
    tick();
  endtask

  initial begin
    // reset with a request pending: nothing may be pushed
    set_req(1, 1, 7, 7, 16'h1234);
    tick();
    chk_en = 1;
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_en", 32'({mem_write_en, mem_read_en}), 0);
    reset = 0;
    set_req(0, 0, 0, 0, 0);
    tick();
    chk("rst_nopush", 32'(count), 0);

    // write row 3 acked after 2 cycles, then read back acked in issue cycle
    ack_mode = 1; dmin = 2; dmax = 2;
    set_req(1, 1, 3, 0, 16'h00A5);
    tick();
    set_req(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("wr_hold_en", 32'(mem_write_en), 1);
      chk("wr_hold_row", 32'(mem_row), 3);
      tick();
    end
    chk("wr_done_count", 32'(count), 0);
    dmin = 0; dmax = 0;
    set_req(1, 0, 3, 0, 0);
    tick();
    set_req(0, 0, 0, 0, 0);
    chk("rd_issue_en", 32'(mem_read_en), 1);
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 1);
    chk("rd_rsp_data", 32'(rsp_data), 32'h00A5);
    tick();
    chk("rd_rsp_pulse", 32'(rsp_valid), 0);
    chk("rd_count", 32'(count), 0);

    // fill to full, reject fifth, single ack while still offering
    ack_mode = 0;
    for (int i = 0; i < 4; i++) begin
      set_req(1, i[0], 10 + i, i, 100 + i);
      tick();
    end
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(req_ready), 0);
    set_req(1, 0, 14, 0, 0);
    tick();
    chk("full_reject", 32'(count), 4);
    ack_once = 1;
    tick();
    set_req(0, 0, 0, 0, 0);
    chk("full_pop_count", 32'(count), 3);
    chk("full_pop_ready", 32'(req_ready), 1);
    chk("full_next_head", 32'(mem_row), 11);
    dmin = 0; dmax = 1;
    drain();

    // simultaneous push and pop at count 2 preserves order
    ack_mode = 0;
    issued.delete();
    set_req(1, 1, 1, 1, 1); tick();
    set_req(1, 1, 2, 2, 2); tick();
    chk("sim_pre", 32'(count), 2);
    set_req(1, 1, 3, 3, 3);
    ack_once = 1;
    tick();
    set_req(0, 0, 0, 0, 0);
    chk("sim_count", 32'(count), 2);
    dmin = 0; dmax = 3;
    drain();
    chk("sim_n", 32'(issued.size()), 3);
    for (int i = 0; i < 3 && i < issued.size(); i++) chk("sim_order", 32'(issued[i]), 32'(i + 1));

    // spurious ack while empty
    ack_mode = 0;
    ack_once = 1;
    tick();
    chk("spur_count", 32'(count), 0);
    chk("spur_rsp", 32'(rsp_valid), 0);

    // pointer wrap: 10 reads rows 0..9 with random ack delays
    issued.delete();
    dut_rsp_n = 0;
    ack_mode = 1; dmin = 0; dmax = 3;
    begin
      int nxt;
      nxt = 0;
      for (int cyc = 0; cyc < 200 && nxt < 10; cyc++) begin
        bit acc;
        set_req(1, 0, nxt, nxt % 16, 0);
        acc = q.size() < DEPTH;
        tick();
        if (acc) nxt++;
      end
      set_req(0, 0, 0, 0, 0);
      chk("wrap_sent", 32'(nxt), 10);
    end
    drain();
    chk("wrap_rsp_n", 32'(dut_rsp_n), 10);
    chk("wrap_n", 32'(issued.size()), 10);
    for (int i = 0; i < 10 && i < issued.size(); i++) chk("wrap_order", 32'(issued[i]), 32'(i));

    // random traffic
    dmin = 0; dmax = 3;
    for (int cyc = 0; cyc < 400; cyc++) begin
      set_req($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 7), $urandom_range(0, 3), $urandom);
      if (q.size() == 0 && $urandom_range(0, 15) == 0) ack_once = 1;
      tick();
    end
    set_req(0, 0, 0, 0, 0);
    drain();

    // reset with writes pending at count 3
    ack_mode = 0;
    for (int i = 0; i < 3; i++) begin
      set_req(1, 1, 20 + i, 0, i);
      tick();
    end
    set_req(0, 0, 0, 0, 0);
    chk("mid_pre", 32'(count), 3);
    reset = 1;
    tick();
    chk("mid_en", 32'({mem_write_en, mem_read_en}), 0);
    chk("mid_count", 32'(count), 0);
    reset = 0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_req_queue.md
# mem_req_queue

Per-bank request queue sitting directly upstream of the bank memory controller. Accepts read/write requests (row, column, partial vector) from the grid-scan and loader logic through a valid/ready handshake and buffers them in a small FIFO. Presents them one at a time to the bank under its enable/ack protocol, holding the request stable until ack. Returns read data as a one-cycle response pulse. One instance per bank (`MACH_N` total).

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears queue and response state.
- req_valid  in  1  upstream request present.
- req_ready  out  1  queue can accept; equals (count < DEPTH).
- req_write  in  1  1 = write, 0 = read.
- req_row  in  `BANK_ADDR_WIDTH  bank row address.
- req_col  in  `COL_ADDR_WIDTH  column address; passed through unmodified.
- req_data  in  `TX_DATA_WIDTH  write partial vector; ignored for reads.
- mem_write_en  out  1  to bank write_en.
- mem_read_en  out  1  to bank read_en.
- mem_row  out  `BANK_ADDR_WIDTH  to bank row_addr_in.
- mem_col  out  `COL_ADDR_WIDTH  to bank col_addr_in.
- mem_wdata  out  `TX_DATA_WIDTH  to bank partial_vec_in.
- mem_ack  in  1  bank completion pulse.
- mem_rdata  in  `TX_DATA_WIDTH  bank partial_vec_out; valid in the ack cycle of a read.
- rsp_valid  out  1  one-cycle pulse: read completed.
- rsp_data  out  `TX_DATA_WIDTH  read data; held until next read response.
- count  out  $clog2(DEPTH)+1  queued entries, including the one at the head being serviced.
- idle  out  1  count == 0 and rsp_valid == 0.

## Operation
- **Storage.** FIFO of {write, row, col, data}, with wr_ptr, rd_ptr and count registers. Pointers wrap modulo DEPTH.
- **Push.** Occurs when req_valid && req_ready at a clock edge. The entry is written at wr_ptr, and wr_ptr increments.
- **Head issue.** While count > 0, the head entry drives the mem_* signals combinationally from the FIFO:
  - mem_write_en = head.write;
  - mem_read_en = !head.write.
- **Empty queue.** When count == 0, both enables are 0, and mem_row, mem_col and mem_wdata are 0.
- **Stability.** The head fields and enable hold constant from first assertion until the mem_ack cycle inclusive. The bank relies on row and column staying stable through its fetch and writeback.
- **Pop.** Occurs on any edge where count > 0 && mem_ack. rd_ptr increments. The next entry, if any, drives mem_* in the following cycle with no idle gap.
- **Read completion.** On a pop of a read, mem_rdata is registered into rsp_data, and rsp_valid = 1 for exactly the next cycle.
- **Write completion.** On a pop of a write, no response is generated.
- **Count update.** count' = count + push − pop. Simultaneous push and pop leaves count unchanged.
- **Full queue.** req_ready is computed from count only, so there is no same-cycle bypass. A pop while full does not allow a push in that same cycle.
- **Spurious ack.** mem_ack with count == 0 is ignored: no pop and no response.
- **Reset values.**
  - count, wr_ptr, rd_ptr = 0.
  - rsp_valid = 0; rsp_data = 0.
  - Therefore req_ready = 1, both enables = 0, and idle = 1.
- **Reset mid-operation.** All queued entries are discarded. Enables deassert in the cycle after reset is sampled. Any in-flight bank operation is abandoned; the bank is reset by the same signal.

## Timing
- **Accept to enable.** A request accepted at edge N into an empty queue asserts its enable during cycle N+1.
- **Ack to pop.** A mem_ack sampled at edge M pops the head at edge M. For a read, rsp_valid is high during cycle M+1.
- **Back-to-back service.** Consecutive queued requests are presented in consecutive cycles following each ack.
- **Enable/ack relation.** An enable is never deasserted before its ack, and never stays asserted past its ack for the same entry.
- **Queue latency.** Added latency is one cycle (accept to issue) plus queueing delay. The bank's own latency is a row hit read in the issue cycle, up to 3 cycles otherwise.
- **Throughput.** One request accepted per cycle while not full.

## Test plan
- **Reset state.** Assert reset for 2 cycles with req_valid = 1 → req_ready = 1, count = 0, enables = 0, rsp_valid = 0, idle = 1, and no push is recorded.
- **Single write then read, same row.**
  - Stimulus: write row 3, col 0, data 0xA5; the bench bank model acks after 2 cycles. Then read row 3, col 0; the model acks in its issue cycle with rdata 0xA5.
  - Required: mem_write_en is held with row 3 until ack. rsp_valid pulses once with rsp_data = 0xA5. count returns to 0.
- **Fill to full.**
  - Stimulus: push 4 requests with mem_ack held 0.
  - Required: req_ready = 0 with count = 4, and a fifth request is not accepted.
  - Then ack once → count = 3, req_ready = 1 the next cycle, and the head advances to entry 2 with no gap.
- **Simultaneous push and pop.** At count = 2, push and ack in the same cycle → count stays 2. Ordering is preserved: rows 1, 2, 3 are issued in order.
- **Pointer wrap-around.** Issue 10 reads on rows 0..9 through a DEPTH = 4 queue, with random ack delays of 0–3 cycles → 10 rsp_valid pulses in row order, with rsp_data matching the model.
- **Edge cases.**
  - A spurious mem_ack while empty → no count change and no rsp_valid.
  - Reset asserted while a write is pending at count = 3 → enables drop next cycle, and count = 0.
